// File: rtl/img_pkg.sv
// img_pkg: shared pixel width default, 3x3 tap indices and window FSM encoding
package img_pkg;
    localparam int DEF_PIX_W = 8;
    localparam int WIN_TAPS  = 9;
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;
    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_e;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one-row pixel store, combinational read of the old word, write on enable
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int W     = DEF_PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] mem_q [DEPTH];

    assign o_rdata = mem_q[i_addr];

    // contents are never reset; rows 0-1 of every frame overwrite them before use
    always_ff @(posedge i_clk)
        if (i_en) mem_q[i_addr] <= i_wdata;
endmodule

// File: rtl/image_window_gen.sv
// image_window_gen: raster stream to 3x3 windows; optional o_line_last under IMG_WIN_LINE_LAST_EN
module image_window_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIX_W      = DEF_PIX_W
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [PIX_W-1:0]          i_pixel_data,
    input  logic                      i_pixel_data_valid,
    output logic [WIN_TAPS*PIX_W-1:0] o_pixel_data,
    output logic                      o_pixel_data_valid,
    output logic                      o_frame_done
`ifdef IMG_WIN_LINE_LAST_EN
    ,
    output logic                      o_line_last
`endif
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_e                    state_q, state_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             row_q, row_d;
    logic [PIX_W-1:0]          win_q [WIN_TAPS];
    logic [PIX_W-1:0]          win_d [WIN_TAPS];
    logic [WIN_TAPS*PIX_W-1:0] data_q, data_d;
    logic                      valid_q, valid_d, done_q, done_d;
    logic [PIX_W-1:0]          lb0_rd, lb1_rd;
    logic                      col_end, row_end;
`ifdef IMG_WIN_LINE_LAST_EN
    logic                      last_q, last_d;
    assign o_line_last = last_q;
`endif

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_frame_done       = done_q;
    assign col_end            = col_q == COL_LAST;
    assign row_end            = row_q == ROW_LAST;

    line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
        .i_clk   (i_clk),
        .i_en    (i_pixel_data_valid),
        .i_addr  (col_q),
        .i_wdata (i_pixel_data),
        .o_rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
        .i_clk   (i_clk),
        .i_en    (i_pixel_data_valid),
        .i_addr  (col_q),
        .i_wdata (lb0_rd),
        .o_rdata (lb1_rd)
    );

    // next state: counters, window shift, output capture and row-gated valid/pulse generation
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
`ifdef IMG_WIN_LINE_LAST_EN
        last_d  = 1'b0;
`endif
        if (i_pixel_data_valid) begin
            col_d          = col_end ? '0 : col_q + 1'b1;
            row_d          = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            win_d[TAP_TL]  = win_q[TAP_TC];
            win_d[TAP_TC]  = win_q[TAP_TR];
            win_d[TAP_TR]  = lb1_rd;
            win_d[TAP_ML]  = win_q[TAP_MC];
            win_d[TAP_MC]  = win_q[TAP_MR];
            win_d[TAP_MR]  = lb0_rd;
            win_d[TAP_BL]  = win_q[TAP_BC];
            win_d[TAP_BC]  = win_q[TAP_BR];
            win_d[TAP_BR]  = i_pixel_data;
            valid_d        = state_q == S_RUN && col_q >= COL_TWO;
            done_d         = state_q == S_RUN && col_end && row_end;
            state_d        = state_q == S_FILL ? ((col_end && row_q == ROW_ONE) ? S_RUN : S_FILL)
                                               : (done_d ? S_FILL : S_RUN);
`ifdef IMG_WIN_LINE_LAST_EN
            last_d         = valid_d && col_end;
`endif
            for (int k = 0; k < WIN_TAPS; k++)
                if (valid_d) data_d[k*PIX_W +: PIX_W] = win_d[k];
        end
    end

    // control and output registers; line buffers and window taps are masked instead of reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_FILL;
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef IMG_WIN_LINE_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef IMG_WIN_LINE_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    // window taps shift on every accepted pixel
    always_ff @(posedge i_clk)
        win_q <= win_d;
endmodule

// File: tb/tb_image_window_gen.sv
// tb_image_window_gen: directed checks of the 3x3 window generator on an 8x6 image
module tb_image_window_gen;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  pix = '0;
    logic        pv = 1'b0;
    logic [71:0] win;
    logic        wv, fd;
`ifdef IMG_WIN_LINE_LAST_EN
    logic        ll;
`endif
    logic [71:0] last_win = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    image_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pv),
        .o_pixel_data       (win),
        .o_pixel_data_valid (wv),
        .o_frame_done       (fd)
`ifdef IMG_WIN_LINE_LAST_EN
        ,
        .o_line_last        (ll)
`endif
    );

    function automatic logic [71:0] exp_win(input int r, input int c, input bit flat, input logic [7:0] fv);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(3*dr+dc)*8 +: 8] = flat ? fv : 8'(16*(r-2+dr) + (c-2+dc));
        return w;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] p);
        pv  = v;
        pix = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input int gap, input bit flat, input logic [7:0] fv, input int first, input int last);
        int   r, c, wins, dones;
        logic ev, ef;
        wins  = 0;
        dones = 0;
        for (int i = first; i < last; i++) begin
            r = i / W;
            c = i % W;
            cycle(1'b1, flat ? fv : 8'(16*r + c));
            ev = (r >= 2 && c >= 2);
            ef = (r == H-1 && c == W-1);
            if (ev) last_win = exp_win(r, c, flat, fv);
            total++;
            if (wv !== ev) begin bad++; $display("FAIL valid r=%0d c=%0d got=%0b exp=%0b", r, c, wv, ev); end
            total++;
            if (win !== last_win) begin bad++; $display("FAIL window r=%0d c=%0d got=%h exp=%h", r, c, win, last_win); end
            total++;
            if (fd !== ef) begin bad++; $display("FAIL frame_done r=%0d c=%0d got=%0b exp=%0b", r, c, fd, ef); end
`ifdef IMG_WIN_LINE_LAST_EN
            total++;
            if (ll !== (ev && c == W-1)) begin bad++; $display("FAIL line_last r=%0d c=%0d got=%0b exp=%0b", r, c, ll, ev && c == W-1); end
`endif
            wins  += int'(wv === 1'b1);
            dones += int'(fd === 1'b1);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 8'hFF);
                total++;
                if (wv !== 1'b0 || fd !== 1'b0 || win !== last_win) begin
                    bad++;
                    $display("FAIL idle_hold r=%0d c=%0d valid=%0b done=%0b got=%h exp=%h", r, c, wv, fd, win, last_win);
                end
            end
        end
        if (first == 0 && last == W*H) begin
            total++;
            if (wins != (W-2)*(H-2)) begin bad++; $display("FAIL window_count got=%0d exp=%0d", wins, (W-2)*(H-2)); end
            total++;
            if (dones != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dones); end
        end
    endtask

    task automatic test_reset();
        total++;
        if (wv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", wv); end
        total++;
        if (win !== 72'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", win); end
        total++;
        if (fd !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", fd); end
`ifdef IMG_WIN_LINE_LAST_EN
        total++;
        if (ll !== 1'b0) begin bad++; $display("FAIL reset_line_last got=%0b exp=0", ll); end
`endif
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        run_frame(0, 1'b0, 8'h00, 0, W*H);
        total++;
        if (win !== 72'h575655474645373635) begin bad++; $display("FAIL last_window got=%h exp=575655474645373635", win); end
    endtask

    task automatic test_toggle();
        run_frame(1, 1'b0, 8'h00, 0, W*H);
    endtask

    task automatic test_back_to_back();
        run_frame(0, 1'b0, 8'h00, 0, W*H);
        run_frame(0, 1'b0, 8'h00, 0, W*H);
    endtask

    task automatic test_mid_reset();
        run_frame(0, 1'b0, 8'h00, 0, 3*W + 5);
        #2 rstn = 1'b0;
        #1;
        total++;
        if (wv !== 1'b0 || fd !== 1'b0 || win !== 72'h0) begin
            bad++;
            $display("FAIL mid_reset valid=%0b done=%0b got=%h exp=0", wv, fd, win);
        end
        last_win = '0;
        @(negedge clk);
        rstn = 1'b1;
        run_frame(0, 1'b0, 8'h00, 0, 2*W + 3);
        total++;
        if (win !== 72'h222120121110020100) begin bad++; $display("FAIL first_window got=%h exp=222120121110020100", win); end
        run_frame(0, 1'b0, 8'h00, 2*W + 3, W*H);
    endtask

    task automatic test_flat();
        run_frame(0, 1'b1, 8'h80, 0, W*H);
        total++;
        if (win !== {9{8'h80}}) begin bad++; $display("FAIL flat_window got=%h exp=%h", win, {9{8'h80}}); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_ramp();
        test_toggle();
        test_back_to_back();
        test_mid_reset();
        test_flat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
